// File: rtl/m_imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the imem it fills.
package m_imem_loader_pkg;

   localparam int IMEM_DEPTH_LOG2 = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/m_byte_packer.sv
// Collects four bytes little-endian into one 32-bit word; byte 0 lands in [7:0].
module m_byte_packer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        accept,
   input  logic [7:0]  byte_in,
   input  logic        clear,
   output logic [31:0] word,
   output logic        full
);

   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [31:0] shift_q, shift_d;

   always_comb begin
      byte_cnt_d = byte_cnt_q;
      shift_d    = shift_q;
      if (clear) begin
         byte_cnt_d = 2'd0;
         shift_d    = 32'd0;
      end else if (accept) begin
         shift_d[{byte_cnt_q, 3'b000} +: 8] = byte_in;
         // Wraps 3 -> 0 so the next word starts in lane 0.
         byte_cnt_d = byte_cnt_q + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt_q <= 2'd0;
         shift_q    <= 32'd0;
      end else begin
         byte_cnt_q <= byte_cnt_d;
         shift_q    <= shift_d;
      end
   end

   assign word = shift_q;
   assign full = (byte_cnt_q == 2'd3);

endmodule

// File: rtl/m_imem_loader.sv
// Fills imem from a byte stream, one word write per 4 bytes, and holds the core in reset until done.
// Byte stream: a byte moves on a posedge where w_byte_valid && w_byte_ready; ready is high only in RECV.
module m_imem_loader
   import m_imem_loader_pkg::*;
#(
   parameter int DEPTH_LOG2 = IMEM_DEPTH_LOG2
) (
   input  logic                  w_clk,
   input  logic                  w_rst_n,
   input  logic                  w_start,
   input  logic [DEPTH_LOG2:0]   w_nwords,
   input  logic                  w_byte_valid,
   input  logic [7:0]            w_byte_data,
   output logic                  w_byte_ready,
   output logic                  w_we,
   output logic [31:0]           w_waddr,
   output logic [31:0]           w_wdata,
   output logic                  w_busy,
   output logic                  w_done,
   output logic                  w_proc_rst_n,
   output state_e                w_dbg_state
);

   localparam int NW = DEPTH_LOG2 + 1;
   localparam logic [NW-1:0] MAX_WORDS = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [NW-1:0] ONE       = {{DEPTH_LOG2{1'b0}}, 1'b1};

   state_e          state_q, state_d;
   logic [NW-1:0]   n_q, n_d;
   logic [NW-1:0]   word_cnt_q, word_cnt_d;
   logic            proc_rst_q, proc_rst_d;
   logic [NW-1:0]   nwords_clamped;
   logic [NW-1:0]   word_cnt_inc;
   logic            pk_accept;
   logic            pk_clear;
   logic            pk_full;
   logic [31:0]     pk_word;

   assign pk_accept      = (state_q == RECV) && w_byte_valid;
   assign nwords_clamped = (w_nwords > MAX_WORDS) ? MAX_WORDS : w_nwords;
   assign word_cnt_inc   = word_cnt_q + ONE;

   m_byte_packer u_packer (
      .clk     (w_clk),
      .rst_n   (w_rst_n),
      .accept  (pk_accept),
      .byte_in (w_byte_data),
      .clear   (pk_clear),
      .word    (pk_word),
      .full    (pk_full)
   );

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      word_cnt_d = word_cnt_q;
      proc_rst_d = proc_rst_q;
      pk_clear   = 1'b0;
      case (state_q)
         IDLE: begin
            if (w_start) begin
               n_d        = nwords_clamped;
               word_cnt_d = '0;
               pk_clear   = 1'b1;
               proc_rst_d = 1'b0;
               state_d    = (nwords_clamped == '0) ? DONE : RECV;
            end
         end
         RECV: begin
            if (pk_accept && pk_full) state_d = WRITE;
         end
         WRITE: begin
            word_cnt_d = word_cnt_inc;
            state_d    = (word_cnt_inc == n_q) ? DONE : RECV;
         end
         DONE: begin
            state_d    = IDLE;
            proc_rst_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         state_q    <= IDLE;
         n_q        <= '0;
         word_cnt_q <= '0;
         proc_rst_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         word_cnt_q <= word_cnt_d;
         proc_rst_q <= proc_rst_d;
      end
   end

   // Address and data are forced to zero outside WRITE so idle outputs stay quiet.
   assign w_byte_ready = (state_q == RECV);
   assign w_we         = (state_q == WRITE);
   assign w_waddr      = w_we ? {{(30-DEPTH_LOG2){1'b0}}, word_cnt_q[DEPTH_LOG2-1:0], 2'b00} : 32'd0;
   assign w_wdata      = w_we ? pk_word : 32'd0;
   assign w_busy       = (state_q == RECV) || (state_q == WRITE);
   assign w_done       = (state_q == DONE);
   assign w_proc_rst_n = proc_rst_q;
   assign w_dbg_state  = state_q;

endmodule

// File: tb/tb_m_imem_loader.sv
// Scenario bench for m_imem_loader: byte-stream driver, expected-write queue, per-scenario checks.
module tb_m_imem_loader;
   import m_imem_loader_pkg::*;

   logic        w_clk;
   logic        w_rst_n;
   logic        w_start;
   logic [8:0]  w_nwords;
   logic        w_byte_valid;
   logic [7:0]  w_byte_data;
   logic        w_byte_ready;
   logic        w_we;
   logic [31:0] w_waddr;
   logic [31:0] w_wdata;
   logic        w_busy;
   logic        w_done;
   logic        w_proc_rst_n;
   state_e      w_dbg_state;

   m_imem_loader #(.DEPTH_LOG2(8)) dut (
      .w_clk        (w_clk),
      .w_rst_n      (w_rst_n),
      .w_start      (w_start),
      .w_nwords     (w_nwords),
      .w_byte_valid (w_byte_valid),
      .w_byte_data  (w_byte_data),
      .w_byte_ready (w_byte_ready),
      .w_we         (w_we),
      .w_waddr      (w_waddr),
      .w_wdata      (w_wdata),
      .w_busy       (w_busy),
      .w_done       (w_done),
      .w_proc_rst_n (w_proc_rst_n),
      .w_dbg_state  (w_dbg_state)
   );

   initial begin
      w_clk = 1'b0;
      forever #5 w_clk = ~w_clk;
   end

   logic [63:0] exp_q[$];
   logic [7:0]  src_q[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc_n = 0;
   int          gap_len = 0;
   int          gap_cnt = 0;
   int          wr_cnt = 0;
   int          prev_we_cyc = -1;
   int          done_cyc = -1;
   bit          chk_spacing = 1'b1;
   logic [31:0] last_addr = 32'd0;

   // Watches every sampled cycle: write stream against the expected queue, ready/proc reset rules.
   task automatic monitor();
      logic [63:0] exp;
      if (w_we) begin
         wr_cnt++;
         last_addr = w_waddr;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got addr=%h data=%h, required no write", w_waddr, w_wdata);
         end else begin
            exp = exp_q.pop_front();
            if ({w_waddr, w_wdata} !== exp) begin
               errors++;
               $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                        w_waddr, w_wdata, exp[63:32], exp[31:0]);
            end
         end
         checks++;
         if (w_byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_write: got %b, required 0", w_byte_ready);
         end
         if (chk_spacing && prev_we_cyc >= 0) begin
            checks++;
            if (cyc_n - prev_we_cyc != 5) begin
               errors++;
               $display("FAIL write_spacing: got %0d cycles, required 5", cyc_n - prev_we_cyc);
            end
         end
         prev_we_cyc = cyc_n;
      end
      if (w_done) done_cyc = cyc_n;
      if (w_busy || w_done) begin
         checks++;
         if (w_proc_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL proc_rst_in_session: got %b, required 0", w_proc_rst_n);
         end
      end
   endtask

   // One clock: retire an accepted byte, sample outputs after the edge, then drive the next byte.
   task automatic cyc();
      logic  acc;
      logic [7:0] dummy;
      acc = w_byte_valid && w_byte_ready;
      @(posedge w_clk);
      if (acc && src_q.size() > 0) begin
         dummy = src_q.pop_front();
         gap_cnt = gap_len;
      end
      #1;
      cyc_n++;
      monitor();
      if (gap_cnt > 0) begin
         w_byte_valid = 1'b0;
         gap_cnt--;
      end else if (src_q.size() > 0) begin
         w_byte_valid = 1'b1;
         w_byte_data  = src_q[0];
      end else begin
         w_byte_valid = 1'b0;
      end
   endtask

   task automatic push_word(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input int idx);
      logic [31:0] a;
      a = idx * 4;
      src_q.push_back(b0);
      src_q.push_back(b1);
      src_q.push_back(b2);
      src_q.push_back(b3);
      exp_q.push_back({a, b3, b2, b1, b0});
   endtask

   task automatic start_session(input int n);
      wr_cnt      = 0;
      prev_we_cyc = -1;
      done_cyc    = -1;
      w_start     = 1'b1;
      w_nwords    = n[8:0];
      cyc();
      w_start     = 1'b0;
      checks++;
      if (w_proc_rst_n !== 1'b0) begin
         errors++;
         $display("FAIL proc_rst_at_start: got %b, required 0", w_proc_rst_n);
      end
   endtask

   task automatic wait_done(input int budget);
      int k;
      k = 0;
      while (!w_done && k < budget) begin
         cyc();
         k++;
      end
      checks++;
      if (w_done !== 1'b1) begin
         errors++;
         $display("FAIL done_timeout: got done=%b after %0d cycles, required 1", w_done, k);
      end
   endtask

   task automatic check_after_done(input int nw);
      checks++;
      if (nw > 0 && done_cyc - prev_we_cyc != 1) begin
         errors++;
         $display("FAIL done_latency: got %0d cycles after last write, required 1", done_cyc - prev_we_cyc);
      end
      checks++;
      if (wr_cnt != nw) begin
         errors++;
         $display("FAIL write_count: got %0d, required %0d", wr_cnt, nw);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_writes: got %0d pending, required 0", exp_q.size());
      end
      cyc();
      checks++;
      if (w_proc_rst_n !== 1'b1 || w_done !== 1'b0) begin
         errors++;
         $display("FAIL proc_rst_release: got proc_rst_n=%b done=%b, required 1 0", w_proc_rst_n, w_done);
      end
   endtask

   task automatic test_reset();
      w_rst_n = 1'b0;
      w_start = 1'b0;
      w_nwords = '0;
      w_byte_valid = 1'b0;
      w_byte_data = '0;
      #2;
      checks++;
      if ({w_byte_ready, w_we, w_busy, w_done, w_proc_rst_n} !== 5'b0 ||
          w_waddr !== 32'd0 || w_wdata !== 32'd0 || w_dbg_state !== IDLE) begin
         errors++;
         $display("FAIL reset_outputs: got rdy=%b we=%b busy=%b done=%b prst=%b addr=%h data=%h, required all 0",
                  w_byte_ready, w_we, w_busy, w_done, w_proc_rst_n, w_waddr, w_wdata);
      end
      cyc();
      cyc();
      w_rst_n = 1'b1;
      for (int i = 0; i < 3; i++) cyc();
      checks++;
      if (w_proc_rst_n !== 1'b0 || w_dbg_state !== IDLE) begin
         errors++;
         $display("FAIL idle_after_reset: got prst=%b state=%0d, required 0 IDLE", w_proc_rst_n, w_dbg_state);
      end
   endtask

   task automatic test_two_word();
      push_word(8'h13, 8'h05, 8'h10, 8'h00, 0);
      push_word(8'h33, 8'h85, 8'h00, 8'h00, 1);
      checks++;
      if (exp_q[0][31:0] !== 32'h00100513 || exp_q[1][31:0] !== 32'h00008533) begin
         errors++;
         $display("FAIL packing_model: got %h %h, required 00100513 00008533", exp_q[0][31:0], exp_q[1][31:0]);
      end
      start_session(2);
      wait_done(100);
      check_after_done(2);
   endtask

   task automatic test_gaps();
      gap_len = 3;
      chk_spacing = 1'b0;
      push_word(8'h13, 8'h05, 8'h10, 8'h00, 0);
      push_word(8'h33, 8'h85, 8'h00, 8'h00, 1);
      start_session(2);
      wait_done(200);
      check_after_done(2);
      gap_len = 0;
      chk_spacing = 1'b1;
   endtask

   task automatic test_zero_len();
      start_session(0);
      checks++;
      if (w_done !== 1'b1 || w_busy !== 1'b0) begin
         errors++;
         $display("FAIL zero_len_done: got done=%b busy=%b, required 1 0", w_done, w_busy);
      end
      check_after_done(0);
   endtask

   task automatic test_clamp();
      for (int i = 0; i < 256; i++)
         push_word(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), i);
      for (int i = 0; i < 176; i++) src_q.push_back(8'($urandom_range(0, 255)));
      start_session(300);
      wait_done(2000);
      check_after_done(256);
      checks++;
      if (last_addr !== 32'h3FC) begin
         errors++;
         $display("FAIL clamp_last_addr: got %h, required 000003fc", last_addr);
      end
      for (int i = 0; i < 10; i++) cyc();
      checks++;
      if (src_q.size() != 176) begin
         errors++;
         $display("FAIL clamp_leftover: got %0d bytes left, required 176", src_q.size());
      end
      src_q.delete();
      cyc();
   endtask

   task automatic test_start_busy();
      push_word(8'($urandom_range(0, 255)), 8'h11, 8'h22, 8'h33, 0);
      push_word(8'h44, 8'h55, 8'($urandom_range(0, 255)), 8'h66, 1);
      start_session(2);
      cyc();
      cyc();
      w_start  = 1'b1;
      w_nwords = 9'd1;
      cyc();
      w_start  = 1'b0;
      wait_done(100);
      check_after_done(2);
      checks++;
      if (last_addr !== 32'h4) begin
         errors++;
         $display("FAIL start_busy_addr: got %h, required 00000004", last_addr);
      end
   endtask

   task automatic test_reset_mid();
      int g;
      push_word(8'h01, 8'h02, 8'h03, 8'h04, 0);
      push_word(8'h05, 8'h06, 8'h07, 8'h08, 1);
      start_session(2);
      g = 0;
      while (src_q.size() > 2 && g < 100) begin
         cyc();
         g++;
      end
      checks++;
      if (src_q.size() != 2 || wr_cnt != 1) begin
         errors++;
         $display("FAIL reset_mid_setup: got %0d bytes left %0d writes, required 2 1", src_q.size(), wr_cnt);
      end
      #3;
      w_rst_n = 1'b0;
      #1;
      checks++;
      if ({w_byte_ready, w_we, w_busy, w_done, w_proc_rst_n} !== 5'b0 ||
          w_waddr !== 32'd0 || w_wdata !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid_outputs: got rdy=%b we=%b busy=%b done=%b prst=%b addr=%h data=%h, required all 0",
                  w_byte_ready, w_we, w_busy, w_done, w_proc_rst_n, w_waddr, w_wdata);
      end
      exp_q.delete();
      src_q.delete();
      w_byte_valid = 1'b0;
      gap_cnt = 0;
      cyc();
      cyc();
      w_rst_n = 1'b1;
      cyc();
      push_word(8'hAA, 8'hBB, 8'hCC, 8'hDD, 0);
      checks++;
      if (exp_q[0][31:0] !== 32'hDDCCBBAA) begin
         errors++;
         $display("FAIL reset_mid_model: got %h, required ddccbbaa", exp_q[0][31:0]);
      end
      start_session(1);
      wait_done(100);
      check_after_done(1);
   endtask

   task automatic test_reload();
      checks++;
      if (w_proc_rst_n !== 1'b1) begin
         errors++;
         $display("FAIL reload_pre: got proc_rst_n=%b, required 1", w_proc_rst_n);
      end
      push_word(8'h93, 8'h00, 8'h50, 8'h00, 0);
      start_session(1);
      wait_done(100);
      check_after_done(1);
   endtask

   initial begin
      test_reset();
      test_two_word();
      test_gaps();
      test_zero_len();
      test_clamp();
      test_start_busy();
      test_reset_mid();
      test_reload();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
